muldiv_seq: RTL

- Iterative multi-cycle multiply/divide unit for the multicycle core.
- Executes MUL, UMUL, SMUL and DIV, selected by the ALUControl code from decode.
- Uses shift-add multiply and restoring division, one bit per cycle.
- Main FSM pulses `start`, stalls while `busy` is high, and writes back `result_lo`/`result_hi` when `done` pulses.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_seq_if.sv | 26 ++
 rtl/muldiv_step.sv | 37 +++
 rtl/muldiv_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes (shared with decode's ALUControl encoding), FSM state
// encoding and small op-classification helpers for muldiv_seq.
package muldiv_pkg;

  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_SMUL = 4'b0101;
  localparam logic [3:0] OP_UMUL = 4'b0110;
  localparam logic [3:0] OP_DIV  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_SMUL) || (op == OP_UMUL) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_mul(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_SMUL) || (op == OP_UMUL);
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle between the core FSM and muldiv_seq.
// Handshake: the master raises start with op/a/b for one cycle; the unit only
// accepts it while idle and with a legal op. busy is high while iterating;
// done pulses for exactly one cycle and result_lo/result_hi/div_by_zero are
// valid from that cycle until the next accepted start.
interface muldiv_seq_if #(parameter int WIDTH = 32) ();
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: combinational single iteration of the shift-add multiplier and
// the restoring divider. Both paths are computed every cycle; the caller picks
// which results to register.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  input  logic [WIDTH-1:0]   rem_i,
  input  logic [WIDTH-1:0]   quo_i,
  input  logic [WIDTH-1:0]   dvsr_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0]   mplier_o,
  output logic [WIDTH-1:0]   rem_o,
  output logic [WIDTH-1:0]   quo_o
);

  // The shifted partial remainder keeps rem's top bit so divisors above
  // 2^(WIDTH-1) still divide correctly; bit WIDTH of the trial is the borrow.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           borrow;

  assign shifted  = {rem_i, quo_i[WIDTH-1]};
  assign trial    = shifted - {1'b0, dvsr_i};
  assign borrow   = trial[WIDTH];

  assign acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
  assign mcand_o  = mcand_i << 1;
  assign mplier_o = mplier_i >> 1;

  assign rem_o    = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_o    = {quo_i[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide unit (MUL, UMUL, SMUL, DIV), one bit
// per cycle. Optional macro MULDIV_EARLY_TERM_EN lets multiplies leave the
// iteration loop once the remaining multiplier is zero; results are the same.
// dbg_state_o exposes the FSM state.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_seq_if.slave   bus,
  output state_e        dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               dbz_q, dbz_d;

  logic [2*WIDTH-1:0] step_acc, step_mcand, acc_fix;
  logic [WIDTH-1:0]   step_mplier, step_rem, step_quo;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic               is_smul_in;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .dvsr_i   (dvsr_q),
    .acc_o    (step_acc),
    .mcand_o  (step_mcand),
    .mplier_o (step_mplier),
    .rem_o    (step_rem),
    .quo_o    (step_quo)
  );

  // SMUL works on magnitudes and fixes the sign at the end; -MIN wraps to
  // MIN, which read unsigned is the correct magnitude 2^(WIDTH-1).
  assign is_smul_in = (bus.op == OP_SMUL);
  assign a_abs      = (is_smul_in && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
  assign b_abs      = (is_smul_in && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
  assign acc_fix    = ((op_q == OP_SMUL) && neg_q) ? (~acc_q + 1'b1) : acc_q;

  // Next-state and datapath: hold everything by default, update per state.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.start && op_legal(bus.op)) begin
          op_d  = bus.op;
          dbz_d = 1'b0;
          cnt_d = '0;
          if (bus.op == OP_DIV) begin
            if (bus.b == '0) begin
              res_lo_d = '1;
              res_hi_d = bus.a;
              dbz_d    = 1'b1;
              state_d  = DONE;
            end else begin
              rem_d   = '0;
              quo_d   = bus.a;
              dvsr_d  = bus.b;
              state_d = ITER;
            end
          end else begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_abs};
            mplier_d = b_abs;
            neg_d    = is_smul_in & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            state_d  = ITER;
          end
        end
      end
      ITER: begin
        cnt_d = cnt_q + 1'b1;
        if (op_is_mul(op_q)) begin
          acc_d    = step_acc;
          mcand_d  = step_mcand;
          mplier_d = step_mplier;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
`ifdef MULDIV_EARLY_TERM_EN
        if (op_is_mul(op_q) && (step_mplier == '0)) begin
          state_d = FIX;
        end
`endif
      end
      FIX: begin
        acc_d = acc_fix;
        if (op_is_mul(op_q)) begin
          res_lo_d = acc_fix[WIDTH-1:0];
          res_hi_d = acc_fix[2*WIDTH-1:WIDTH];
        end else begin
          res_lo_d = quo_q;
          res_hi_d = rem_q;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == ITER) || (state_q == FIX);
  assign bus.done        = (state_q == DONE);
  assign bus.result_lo   = res_lo_q;
  assign bus.result_hi   = res_hi_q;
  assign bus.div_by_zero = dbz_q;
  assign dbg_state_o     = state_q;

endmodule
